freq_gen: RTL and testbench

Programmable square-wave generator that drives the `signal` input of `freq_counter`. It produces a waveform with a period set in `clk` cycles, so a known frequency can be generated and measured on the same clock. A new period is adopted only at a period boundary, so no runt pulses are produced. It is the source end of the signal path that `freq_counter` measures.

---
 rtl/freq_gen_pkg.sv | 30 +++
 rtl/freq_gen_if.sv | 23 ++
 rtl/freq_gen_shadow.sv | 71 +++++++
 rtl/freq_gen.sv | 87 ++++++++
 tb/tb_freq_gen.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/freq_gen_pkg.sv
// Shared types and helpers for the freq_gen square-wave generator.
// clamp_high is only referenced when FREQ_GEN_DUTY_EN is defined.
package freq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

    // Helpers work on 64-bit values; callers size-cast to their own WIDTH.
    function automatic logic [63:0] clamp_period(input logic [63:0] p);
        return (p < 64'(MIN_PERIOD)) ? 64'(MIN_PERIOD) : p;
    endfunction

    function automatic logic [63:0] half_period(input logic [63:0] p);
        return p >> 1;
    endfunction

    function automatic logic [63:0] clamp_high(input logic [63:0] p, input logic [63:0] h);
        if (h < 64'd1)
            return 64'd1;
        if (h > p - 64'd1)
            return p - 64'd1;
        return h;
    endfunction

endpackage

// File: rtl/freq_gen_if.sv
// Control/status bundle for freq_gen; high_in exists only with FREQ_GEN_DUTY_EN.
interface freq_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] period_in;
`ifdef FREQ_GEN_DUTY_EN
    logic [WIDTH-1:0] high_in;
`endif
    logic             load;
    logic             signal;
    logic             load_ack;
    logic [WIDTH-1:0] edge_count;

`ifdef FREQ_GEN_DUTY_EN
    modport master (output en, period_in, high_in, load, input signal, load_ack, edge_count);
    modport slave  (input en, period_in, high_in, load, output signal, load_ack, edge_count);
`else
    modport master (output en, period_in, load, input signal, load_ack, edge_count);
    modport slave  (input en, period_in, load, output signal, load_ack, edge_count);
`endif

endinterface

// File: rtl/freq_gen_shadow.sv
// Pending/active period registers: values load into the pending pair and are
// adopted (clamped) only on a boundary cycle. Duty input with FREQ_GEN_DUTY_EN.
module freq_gen_shadow
    import freq_gen_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
`ifdef FREQ_GEN_DUTY_EN
    input  logic [WIDTH-1:0] high_in,
`endif
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] h,
    output logic             load_ack
);

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(clamp_period(64'(DEFAULT_PERIOD)));
    localparam logic [WIDTH-1:0] RST_H = WIDTH'(half_period(64'(RST_P)));

    logic             pend;
    logic [WIDTH-1:0] pend_p;
`ifdef FREQ_GEN_DUTY_EN
    logic [WIDTH-1:0] pend_h;
`endif
    logic             adopt;
    logic [WIDTH-1:0] new_p;
    logic [WIDTH-1:0] new_h;

    // A load landing in the boundary cycle bypasses the pending register.
    always_comb begin
        adopt = boundary && (load || pend);
        new_p = WIDTH'(clamp_period(64'(load ? period_in : pend_p)));
`ifdef FREQ_GEN_DUTY_EN
        new_h = WIDTH'(clamp_high(64'(new_p), 64'(load ? high_in : pend_h)));
`else
        new_h = WIDTH'(half_period(64'(new_p)));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_p   <= '0;
`ifdef FREQ_GEN_DUTY_EN
            pend_h   <= '0;
`endif
            p        <= RST_P;
            h        <= RST_H;
            load_ack <= 1'b0;
        end else begin
            load_ack <= adopt;
            if (adopt) begin
                p    <= new_p;
                h    <= new_h;
                pend <= 1'b0;
            end else if (load) begin
                pend   <= 1'b1;
                pend_p <= period_in;
`ifdef FREQ_GEN_DUTY_EN
                pend_h <= high_in;
`endif
            end
        end
    end

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave source: H cycles high, P-H low, new period adopted
// only at a period boundary. Programmable duty via FREQ_GEN_DUTY_EN.
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    freq_gen_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] edge_cnt;
    logic             sig;
    logic             ack;
    logic             boundary;

    assign boundary = (state == IDLE) || ((state == LOW) && (cnt == p - ONE));

    freq_gen_shadow #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .load      (bus.load),
        .period_in (bus.period_in),
`ifdef FREQ_GEN_DUTY_EN
        .high_in   (bus.high_in),
`endif
        .p         (p),
        .h         (h),
        .load_ack  (ack)
    );

    // signal is registered from the state, so it trails the FSM by one cycle;
    // edge_cnt counts in that same cycle so it tracks real rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sig      <= 1'b0;
            edge_cnt <= '0;
        end else begin
            sig <= (state == HIGH);
            if ((state == HIGH) && !sig)
                edge_cnt <= edge_cnt + ONE;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.en)
                        state <= HIGH;
                end
                HIGH: begin
                    cnt <= cnt + ONE;
                    if (cnt == h - ONE)
                        state <= LOW;
                end
                LOW: begin
                    if (cnt == p - ONE) begin
                        cnt   <= '0;
                        state <= bus.en ? HIGH : IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.signal     = sig;
    assign bus.load_ack   = ack;
    assign bus.edge_count = edge_cnt;

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen; duty-cycle steps compile only with FREQ_GEN_DUTY_EN.
module tb_freq_gen;

    logic clk;
    logic rst;
    int unsigned tests;
    int unsigned fails;

    freq_gen_if #(.WIDTH(32)) bus ();

    freq_gen #(
        .WIDTH          (32),
        .DEFAULT_PERIOD (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.load      = 1'b0;
        bus.period_in = '0;
`ifdef FREQ_GEN_DUTY_EN
        bus.high_in   = '0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    // Starts on a sample; counts consecutive high then low samples (bounded).
    task automatic measure(input int unsigned cap, output int unsigned hi,
                           output int unsigned lo, output int unsigned acks);
        hi = 0;
        lo = 0;
        acks = 0;
        while (bus.signal === 1'b1 && hi < cap) begin
            if (bus.load_ack === 1'b1) acks++;
            hi++;
            step();
        end
        while (bus.signal === 1'b0 && lo < cap) begin
            if (bus.load_ack === 1'b1) acks++;
            lo++;
            step();
        end
    endtask

    task automatic check_period(input string tag, input int unsigned exp_hi,
                                input int unsigned exp_lo, input int unsigned exp_acks);
        int unsigned hi, lo, acks;
        measure(40, hi, lo, acks);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_ack"}, 64'(acks), 64'(exp_acks));
    endtask

    logic [29:0] wave;
    int unsigned hi_n, lo_n, ack_n;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;

        // 1: reset state and default P=10 free run
        do_reset();
        check("rst_signal", 64'(bus.signal), 64'd0);
        check("rst_ack", 64'(bus.load_ack), 64'd0);
        check("rst_edges", 64'(bus.edge_count), 64'd0);
        bus.en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            wave[i] = bus.signal;
        end
        check("p10_wave", 64'(wave), 64'(30'b000011111000001111100000111110));
        check("p10_edges", 64'(bus.edge_count), 64'd3);

        // 2: load P=7 while idle, then run
        do_reset();
        bus.load = 1'b1;
        bus.period_in = 32'd7;
        step();
        bus.load = 1'b0;
        check("p7_ack_on", 64'(bus.load_ack), 64'd1);
        step();
        check("p7_ack_off", 64'(bus.load_ack), 64'd0);
        bus.en = 1'b1;
        step();
        check("p7_pre_rise", 64'(bus.signal), 64'd0);
        step();
        check("p7_rise", 64'(bus.signal), 64'd1);
        check_period("p7_a", 3, 4, 0);
        check_period("p7_b", 3, 4, 0);

        // 3: reload mid-HIGH (P=6 then P=4); only the last is adopted, one ack
        do_reset();
        bus.en = 1'b1;
        step();
        step();
        check("p4_rise", 64'(bus.signal), 64'd1);
        step();
        bus.load = 1'b1;
        bus.period_in = 32'd6;
        step();
        bus.period_in = 32'd4;
        step();
        bus.load = 1'b0;
        check_period("p4_cur", 2, 5, 1);
        check_period("p4_a", 2, 2, 0);
        check_period("p4_b", 2, 2, 0);

        // 4: P=0 and P=1 both clamp to 2
        do_reset();
        bus.load = 1'b1;
        bus.period_in = 32'd0;
        step();
        bus.load = 1'b0;
        check("p0_ack", 64'(bus.load_ack), 64'd1);
        bus.en = 1'b1;
        step();
        step();
        check("p0_rise", 64'(bus.signal), 64'd1);
        check_period("p0_a", 1, 1, 0);
        bus.load = 1'b1;
        bus.period_in = 32'd1;
        step();
        bus.load = 1'b0;
        check("p1_ack", 64'(bus.load_ack), 64'd1);
        check("p1_low", 64'(bus.signal), 64'd0);
        step();
        check_period("p1_a", 1, 1, 0);
        check_period("p1_b", 1, 1, 0);

        // 5: en dropped in second HIGH cycle completes the period then idles
        do_reset();
        bus.en = 1'b1;
        step();
        step();
        step();
        bus.en = 1'b0;
        measure(20, hi_n, lo_n, ack_n);
        check("endrop_hi", 64'(hi_n), 64'd4);
        check("endrop_held", 64'(lo_n), 64'd20);
        check("endrop_edges", 64'(bus.edge_count), 64'd1);

        // 6: rst mid-HIGH with a pending load and a simultaneous load
        do_reset();
        bus.en = 1'b1;
        step();
        step();
        step();
        bus.load = 1'b1;
        bus.period_in = 32'd4;
        step();
        rst = 1'b1;
        bus.period_in = 32'd6;
        step();
        check("rstmid_signal", 64'(bus.signal), 64'd0);
        check("rstmid_edges", 64'(bus.edge_count), 64'd0);
        check("rstmid_ack", 64'(bus.load_ack), 64'd0);
        rst = 1'b0;
        bus.load = 1'b0;
        step();
        check("rstmid_noack", 64'(bus.load_ack), 64'd0);
        step();
        check("rstmid_rise", 64'(bus.signal), 64'd1);
        check_period("rstmid_p10", 5, 5, 0);

`ifdef FREQ_GEN_DUTY_EN
        // 7: programmable duty with clamping of H
        do_reset();
        bus.load = 1'b1;
        bus.period_in = 32'd10;
        bus.high_in = 32'd3;
        step();
        bus.load = 1'b0;
        check("h3_ack", 64'(bus.load_ack), 64'd1);
        bus.en = 1'b1;
        step();
        step();
        check_period("h3", 3, 7, 0);
        bus.load = 1'b1;
        bus.high_in = 32'd0;
        step();
        bus.load = 1'b0;
        check_period("h0_cur", 2, 7, 1);
        check_period("h0", 1, 9, 0);
        bus.load = 1'b1;
        bus.high_in = 32'd12;
        step();
        bus.load = 1'b0;
        check_period("h12_cur", 0, 9, 1);
        check_period("h12", 9, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
